vga_stream_receiver: RTL
========================

Name: vga_stream_receiver

Overview:
- Receive end of the 640x480 VGA interface driven by the display peripheral.
- Consumes the VGA_CLK, HS, VS, BLANK_n and RGB signals, all sampled in the 50 MHz system clock domain.
- Recovers pixel coordinates, checks frame geometry and locks to the stream.
- Emits a qualified pixel stream for on-chip capture and hardware self-test of the raycaster display path.

Parameters:
- H_ACTIVE, 640: required active pixels per line.
- V_ACTIVE, 480: required active lines per frame.
- ERR_W, 8: width of the saturating error counter.

Ports:
- clk  input  1  50 MHz system clock.
- reset_n  input  1  asynchronous, active-low reset.
- VGA_CLK  input  1  pixel clock, sampled as data; a rising edge marks a pixel tick.
- VGA_HS  input  1  horizontal sync, active low.
- VGA_VS  input  1  vertical sync, active low.
- VGA_BLANK_n  input  1  high during active video.
- VGA_R, VGA_G, VGA_B  input  8 each  pixel colour.
- err_clr  input  1  one-cycle pulse that clears err_count.
- pix_valid  output  1  one-cycle strobe for a captured active pixel.
- pix_x  output  10  column, 0..H_ACTIVE-1.
- pix_y  output  10  row, 0..V_ACTIVE-1.
- pix_rgb  output  24  {R,G,B} of the pixel.
- frame_start  output  1  one-cycle pulse at the start of each locked frame.
- locked  output  1  high while the stream geometry matches the parameters.
- err_count  output  ERR_W  number of geometry errors seen while locked; saturating.

Behaviour:
- Reset is asynchronous on reset_n low. It forces:
  - all outputs to 0,
  - all counters to 0,
  - the input pipeline to 0,
  - the state machine to HUNT.
- Reset taking effect mid-line or mid-frame discards that line or frame.
- Input stage: every input is registered once (s1), and s1 is registered again (s2).
- Tick: asserted when s1.VGA_CLK=1 and s2.VGA_CLK=0. HS, VS, BLANK_n and RGB are taken from s1 at the tick.
- Edge detection on HS, VS and BLANK_n happens only at ticks, comparing against their values at the previous tick.
- Latency: for pins sampled at clk edge N, where N is the edge at which VGA_CLK is first seen high, pix_valid, pix_x, pix_y and pix_rgb are registered at edge N+2. pix_valid is high for exactly one clk cycle.
- x counter, 11 bits, saturates at 2047:
  - cleared on a BLANK_n rising tick; that pixel is x=0;
  - incremented on every tick with BLANK_n=1.
- Line check: on a BLANK_n falling tick, active_len (the x count reached) is compared with H_ACTIVE.
- y counter, 10 bits, saturates at 1023:
  - incremented on an HS falling tick, only if the line just ended had active pixels;
  - cleared on a VS falling tick.
- Frame check: on a VS falling tick, lines_seen is compared with V_ACTIVE.
- State machine:
  - HUNT: pix_valid=0 and locked=0. A VS falling tick moves to SYNC.
  - SYNC: the first full frame is checked. Any line or frame mismatch returns to HUNT without counting. A VS falling tick with every line and the frame matching moves to LOCKED.
  - LOCKED: locked=1, and every active tick produces pix_valid. frame_start pulses on each VS falling tick, including the one that entered LOCKED, in the same cycle as its registered outputs. The first pix_valid after frame_start has x=0, y=0.
    - Any mismatch in LOCKED increments err_count, moves to HUNT and drops locked in the same registered update.
    - The pixel on the mismatching tick is not emitted.
- err_count saturates at 2^ERR_W-1.
- err_clr resets err_count to 0. If err_clr and an error occur in the same cycle, the result is 1.
- A VS falling tick in the same tick as a BLANK_n falling edge performs the line check first, then the frame check.
- HS and VS edges that occur while BLANK_n=1 are illegal and count as a mismatch.

Test Plan:
- Reset, then drive 3 frames of standard 640x480 timing (1600-clk lines, 525 lines, VGA_CLK = hcount[0]):
  - locked rises at the 2nd VS falling tick;
  - frame_start pulses once per frame;
  - exactly 307200 pix_valid pulses per locked frame;
  - the first pulse has x=0, y=0 and the last has x=639, y=479.
- Drive RGB = {x[7:0], y[7:0], 8'h5A} from the generator:
  - every pix_valid carries a matching pix_rgb;
  - pix_valid follows the VGA_CLK rise by exactly 2 clk cycles.
- While locked, shorten line 100 to 639 active pixels:
  - err_count becomes 1 and locked drops;
  - no further pix_valid;
  - relock occurs after two clean VS falling ticks.
- While locked, send a frame with 479 active lines:
  - err_count increments at the VS fall and locked drops.
- Assert reset_n low mid-line while locked:
  - all outputs are 0 before the next clk edge;
  - after release, the block re-locks within 2 frames;
  - err_count stays 0.
- Inject 300 errors, each followed by a relock:
  - err_count holds at 255;
  - err_clr returns it to 0;
  - err_clr coincident with an error gives 1.

Source files
------------

// File: rtl/vga_stream_receiver.sv
// Receive side of the VGA display interface: oversamples the pins in the system clock domain,
// recovers pixel coordinates, checks frame geometry and emits a qualified pixel stream.
module vga_stream_receiver #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned ERR_W    = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             VGA_CLK,
  input  logic             VGA_HS,
  input  logic             VGA_VS,
  input  logic             VGA_BLANK_n,
  input  logic [7:0]       VGA_R,
  input  logic [7:0]       VGA_G,
  input  logic [7:0]       VGA_B,
  input  logic             err_clr,
  output logic             pix_valid,
  output logic [9:0]       pix_x,
  output logic [9:0]       pix_y,
  output logic [23:0]      pix_rgb,
  output logic             frame_start,
  output logic             locked,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [1:0] {StHunt, StSync, StLocked} state_e;

  state_e state_q, state_d;

  logic        s1_clk_q, s1_hs_q, s1_vs_q, s1_blank_q, s2_clk_q;
  logic [23:0] s1_rgb_q;
  logic        t_tick_q, t_hs_q, t_vs_q, t_blank_q;
  logic [23:0] t_rgb_q;
  logic        hs_prev_q, vs_prev_q, blank_prev_q;
  logic [10:0] x_cnt_q, x_d, x_cur;
  logic [9:0]  y_cnt_q, y_d;
  logic        line_act_q, line_act_d;
  logic [ERR_W-1:0] err_q, err_d;

  logic blank_rise, blank_fall, hs_fall, vs_fall, sync_edge;
  logic line_err, frame_err, sync_err, mismatch;
  logic emit, fs, err_inc;

  // The t_* stage holds the pins captured at a tick, so all tracking runs one cycle later.
  assign blank_rise = t_tick_q & t_blank_q & ~blank_prev_q;
  assign blank_fall = t_tick_q & ~t_blank_q & blank_prev_q;
  assign hs_fall    = t_tick_q & ~t_hs_q & hs_prev_q;
  assign vs_fall    = t_tick_q & ~t_vs_q & vs_prev_q;
  assign sync_edge  = t_tick_q & ((t_hs_q ^ hs_prev_q) | (t_vs_q ^ vs_prev_q));

  assign line_err  = blank_fall & (x_cnt_q != 11'(H_ACTIVE));
  assign frame_err = vs_fall & (y_cnt_q != 10'(V_ACTIVE));
  assign sync_err  = sync_edge & t_blank_q;
  assign mismatch  = line_err | frame_err | sync_err;

  always_comb begin
    x_cur = blank_rise ? 11'd0 : x_cnt_q;
    x_d   = x_cnt_q;
    if (t_tick_q && t_blank_q) begin
      x_d = (x_cur == 11'h7ff) ? x_cur : x_cur + 11'd1;
    end

    y_d = y_cnt_q;
    if (vs_fall) begin
      y_d = 10'd0;
    end else if (hs_fall && line_act_q && (y_cnt_q != 10'h3ff)) begin
      y_d = y_cnt_q + 10'd1;
    end

    line_act_d = line_act_q;
    if (hs_fall) begin
      line_act_d = 1'b0;
    end else if (t_tick_q && t_blank_q) begin
      line_act_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    emit    = 1'b0;
    fs      = 1'b0;
    err_inc = 1'b0;
    case (state_q)
      StHunt: begin
        if (vs_fall) state_d = StSync;
      end
      StSync: begin
        if (mismatch) begin
          state_d = StHunt;
        end else if (vs_fall) begin
          state_d = StLocked;
          fs      = 1'b1;
        end
      end
      StLocked: begin
        if (mismatch) begin
          state_d = StHunt;
          err_inc = 1'b1;
        end else begin
          emit = t_tick_q & t_blank_q;
          fs   = vs_fall;
        end
      end
      default: state_d = StHunt;
    endcase
  end

  // A clear that coincides with an error leaves exactly that one error counted.
  always_comb begin
    err_d = err_q;
    if (err_clr) begin
      err_d = err_inc ? ERR_W'(1) : '0;
    end else if (err_inc && (err_q != {ERR_W{1'b1}})) begin
      err_d = err_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_clk_q     <= 1'b0;
      s1_hs_q      <= 1'b0;
      s1_vs_q      <= 1'b0;
      s1_blank_q   <= 1'b0;
      s1_rgb_q     <= '0;
      s2_clk_q     <= 1'b0;
      t_tick_q     <= 1'b0;
      t_hs_q       <= 1'b0;
      t_vs_q       <= 1'b0;
      t_blank_q    <= 1'b0;
      t_rgb_q      <= '0;
      hs_prev_q    <= 1'b0;
      vs_prev_q    <= 1'b0;
      blank_prev_q <= 1'b0;
      x_cnt_q      <= '0;
      y_cnt_q      <= '0;
      line_act_q   <= 1'b0;
      err_q        <= '0;
      state_q      <= StHunt;
      pix_valid    <= 1'b0;
      pix_x        <= '0;
      pix_y        <= '0;
      pix_rgb      <= '0;
      frame_start  <= 1'b0;
    end else begin
      s1_clk_q   <= VGA_CLK;
      s1_hs_q    <= VGA_HS;
      s1_vs_q    <= VGA_VS;
      s1_blank_q <= VGA_BLANK_n;
      s1_rgb_q   <= {VGA_R, VGA_G, VGA_B};
      s2_clk_q   <= s1_clk_q;
      t_tick_q   <= s1_clk_q & ~s2_clk_q;
      t_hs_q     <= s1_hs_q;
      t_vs_q     <= s1_vs_q;
      t_blank_q  <= s1_blank_q;
      t_rgb_q    <= s1_rgb_q;
      if (t_tick_q) begin
        hs_prev_q    <= t_hs_q;
        vs_prev_q    <= t_vs_q;
        blank_prev_q <= t_blank_q;
      end
      x_cnt_q     <= x_d;
      y_cnt_q     <= y_d;
      line_act_q  <= line_act_d;
      err_q       <= err_d;
      state_q     <= state_d;
      pix_valid   <= emit;
      frame_start <= fs;
      if (emit) begin
        pix_x   <= x_cur[9:0];
        pix_y   <= y_cnt_q;
        pix_rgb <= t_rgb_q;
      end
    end
  end

  assign locked    = (state_q == StLocked);
  assign err_count = err_q;

endmodule
